// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_pkg
// Shared definitions for the nibble-serial adder: the sequencing FSM state
// type, the nibble width, and a helper that sizes the nibble counter.
// No ports.
// -----------------------------------------------------------------------------
package nibble_serial_adder_pkg;

   localparam int unsigned NibW = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   // Counter width for 'nib' nibbles; a single-nibble adder still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

endpackage

// File: rtl/cla.sv
// -----------------------------------------------------------------------------
// cla
// Existing 4-bit carry-lookahead adder, purely combinational.
// Ports:
//   a, b  in  4 : addends
//   cin   in  1 : carry in
//   s     out 4 : a + b + cin (low 4 bits)
//   cout  out 1 : carry out of bit 3
// -----------------------------------------------------------------------------
module cla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Every carry is a flat sum-of-products of generate/propagate terms.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

   assign s    = w_p ^ w_c[3:0];
   assign cout = w_c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// WIDTH-bit adder that streams operands through one 4-bit cla, least
// significant nibble first, carrying between nibbles in a register.
// Ports:
//   i_clk        in  1     : clock, rising edge
//   i_rst_n      in  1     : synchronous active-low reset
//   i_in_valid   in  1     : operand pair and carry-in valid
//   o_in_ready   out 1     : operands can be accepted this cycle
//   i_a, i_b     in  WIDTH : operands (unsigned or two's complement)
//   i_cin        in  1     : carry into nibble 0
//   o_out_valid  out 1     : result valid
//   i_out_ready  in  1     : consumer takes result this cycle
//   o_sum        out WIDTH : a + b + cin mod 2^WIDTH
//   o_cout       out 1     : carry out of the top nibble
//   o_ovf        out 1     : signed overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int unsigned Nib  = WIDTH / NibW;
   localparam int unsigned CntW = cnt_width(Nib);

   if ((WIDTH % NibW) != 0 || WIDTH < NibW) begin : g_width_check
      $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
   end

   state_e           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_sum_sh;
   logic             r_carry;
   logic [CntW-1:0]  r_cnt;
   logic             r_a_msb;
   logic             r_b_msb;

   logic [NibW-1:0]  w_s;
   logic             w_cout;
   logic [WIDTH-1:0] w_sum_next;
   logic             w_accept;

   cla u_cla (
      .a    (r_a_sh[NibW-1:0]),
      .b    (r_b_sh[NibW-1:0]),
      .cin  (r_carry),
      .s    (w_s),
      .cout (w_cout)
   );

   // New nibble enters from the top so that after Nib shifts nibble 0 sits at
   // the bottom.
   if (WIDTH == NibW) begin : g_sum_single
      assign w_sum_next = w_s;
   end else begin : g_sum_multi
      assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:NibW]};
   end

   assign o_in_ready = (r_state == StIdle) || ((r_state == StDone) && i_out_ready);
   assign w_accept   = i_in_valid && o_in_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_a_msb  <= 1'b0;
         r_b_msb  <= 1'b0;
      end else if (w_accept) begin
         // Only reachable from IDLE or from DONE with the result taken.
         r_a_sh  <= i_a;
         r_b_sh  <= i_b;
         r_carry <= i_cin;
         r_cnt   <= '0;
         r_a_msb <= i_a[WIDTH-1];
         r_b_msb <= i_b[WIDTH-1];
         r_state <= StRun;
      end else begin
         case (r_state)
            StIdle: ;
            StRun: begin
               r_sum_sh <= w_sum_next;
               r_a_sh   <= r_a_sh >> NibW;
               r_b_sh   <= r_b_sh >> NibW;
               r_carry  <= w_cout;
               r_cnt    <= r_cnt + CntW'(1);
               if (r_cnt == CntW'(Nib - 1)) begin
                  r_state <= StDone;
               end
            end
            StDone: begin
               if (i_out_ready) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_out_valid = (r_state == StDone);
   assign o_sum       = r_sum_sh;
   assign o_cout      = r_carry;
   assign o_ovf       = (r_a_msb == r_b_msb) && (r_sum_sh[WIDTH-1] != r_a_msb);

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

   localparam int unsigned W   = 16;
   localparam int unsigned Nib = W / 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  a, b, sum;
   logic          cin, cout, ovf;

   logic          in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]    a4, b4, sum4;
   logic          cin4, cout4, ovf4;

   int unsigned   n_chk  = 0;
   int unsigned   n_pass = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(W)) u_dut16 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_a         (a),
      .i_b         (b),
      .i_cin       (cin),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_sum       (sum),
      .o_cout      (cout),
      .o_ovf       (ovf)
   );

   nibble_serial_adder #(.WIDTH(4)) u_dut4 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid4),
      .o_in_ready  (in_ready4),
      .i_a         (a4),
      .i_b         (b4),
      .i_cin       (cin4),
      .o_out_valid (out_valid4),
      .i_out_ready (out_ready4),
      .o_sum       (sum4),
      .o_cout      (cout4),
      .o_ovf       (ovf4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Transaction-level model of the 16-bit instance: an accepted pair becomes
   // a visible result Nib cycles later and stays until it is taken.
   int unsigned   cyc      = 0;
   bit            m_have   = 1'b0;
   int unsigned   m_rdy    = 0;
   logic [W-1:0]  m_sum    = '0;
   bit            m_cout   = 1'b0;
   bit            m_ovf    = 1'b0;
   int unsigned   m_acc    = 0;
   bit            chk_en   = 1'b0;

   always @(posedge clk) begin : model
      bit          v, rdy;
      logic [W:0]  wide;
      int          sa, sb, st;
      v   = m_have && (cyc >= m_rdy);
      rdy = !m_have || (v && out_ready);
      if (!rst_n) begin
         m_have = 1'b0;
      end else begin
         if (v && out_ready) m_have = 1'b0;
         if (in_valid && rdy) begin
            wide   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            sa     = $signed(a);
            sb     = $signed(b);
            st     = sa + sb + (cin ? 1 : 0);
            m_sum  = wide[W-1:0];
            m_cout = wide[W];
            m_ovf  = (st > 32767) || (st < -32768);
            m_have = 1'b1;
            m_rdy  = cyc + 1 + Nib;
            m_acc++;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin : compare
      bit v;
      if (chk_en) begin
         v = m_have && (cyc >= m_rdy);
         check("in_ready", 32'(in_ready), 32'(!m_have || (v && out_ready)));
         check("out_valid", 32'(out_valid), 32'(v));
         if (v) begin
            check("sum", 32'(sum), 32'(m_sum));
            check("cout", 32'(cout), 32'(m_cout));
            check("ovf", 32'(ovf), 32'(m_ovf));
         end
      end
   end

   task automatic wait_valid16(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Issue one pair on an idle 16-bit DUT, check latency and result, stall the
   // consumer for 'hold' cycles with a competing pair offered, then drain.
   task automatic op16(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input int hold);
      int n;
      in_valid = 1'b1; a = ia; b = ib; cin = ic;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid16(n);
      check("latency", 32'(n), 32'(Nib));
      check("lit_sum", 32'(sum), 32'(es));
      check("lit_cout", 32'(cout), 32'(ec));
      check("lit_ovf", 32'(ovf), 32'(eo));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = ~ia; b = ~ib; out_ready = 1'b0;
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_sum", 32'(sum), 32'(es));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("drained_valid", 32'(out_valid), 32'd0);
      check("drained_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      int unsigned start, guard;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 3);

      // Back-to-back: the second pair is accepted in the first pair's DONE cycle.
      in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid16(n);
      check("b2b1_latency", 32'(n), 32'(Nib));
      check("b2b1_sum", 32'(sum), 32'h8000);
      check("b2b1_cout", 32'(cout), 32'd0);
      check("b2b1_ovf", 32'(ovf), 32'd1);
      in_valid = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      check("b2b2_accepted_run", 32'(in_ready), 32'd0);
      check("b2b2_not_valid", 32'(out_valid), 32'd0);
      wait_valid16(n);
      check("b2b2_latency", 32'(n), 32'(Nib));
      check("b2b2_sum", 32'(sum), 32'h0000);
      check("b2b2_cout", 32'(cout), 32'd1);
      check("b2b2_ovf", 32'(ovf), 32'd1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset while cnt==2 in RUN.
      in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; cin = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("midrst_no_stale", 32'(out_valid), 32'd0);
      end
      out_ready = 1'b0;

      // Random traffic with stalls on both sides.
      start = m_acc;
      guard = 0;
      while ((m_acc - start) < 1000 && guard < 20000) begin
         in_valid  = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a   = 16'($urandom);
         b   = 16'($urandom);
         cin = 1'($urandom);
         if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
         if ($urandom_range(0, 9) == 0) b = 16'h8000;
         @(posedge clk); #1;
         guard++;
      end
      check("random_accepts", 32'((m_acc - start) >= 1000), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (Nib + 2) begin
         @(posedge clk); #1;
      end
      check("random_drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Single-nibble instance.
      in_valid4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("w4_latency", 32'(n), 32'd1);
      check("w4_sum", 32'(sum4), 32'h1);
      check("w4_cout", 32'(cout4), 32'd1);
      check("w4_ovf", 32'(ovf4), 32'd0);
      in_valid4 = 1'b1; a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0; out_ready4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0; out_ready4 = 1'b0;
      check("w4_b2b_not_valid", 32'(out_valid4), 32'd0);
      @(posedge clk); #1;
      check("w4_b2b_valid", 32'(out_valid4), 32'd1);
      check("w4_b2b_sum", 32'(sum4), 32'h8);
      check("w4_b2b_cout", 32'(cout4), 32'd0);
      check("w4_b2b_ovf", 32'(ovf4), 32'd1);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check("w4_idle", 32'(in_ready4), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder built around the team's existing 4-bit carry-lookahead adder `cla`. It accepts a pair of wide operands over a valid/ready handshake and feeds them to a single `cla` instance one nibble per cycle, least-significant nibble first. It registers the inter-nibble carry and assembles the result, then presents sum, carry-out and signed overflow on a valid/ready output. It sits directly upstream of `cla` and owns all sequencing; `cla` stays purely combinational.

## Interface
- `WIDTH`, default 16: operand width in bits; must be a multiple of 4 and at least 4. `NIB = WIDTH/4`.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset; synchronous, active-low.
- `in_valid`  in  1: operand pair and `cin` are valid.
- `in_ready`  out  1: block can accept operands this cycle.
- `a`  in  WIDTH: operand A (two's complement or unsigned).
- `b`  in  WIDTH: operand B.
- `cin`  in  1: carry into nibble 0.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer takes result this cycle.
- `sum`  out  WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`  out  1: carry out of the MSB nibble.
- `ovf`  out  1: signed overflow.

## Operation
- FSM states are IDLE, RUN and DONE.
- Reset (`rst_n`=0 at an edge): state goes to IDLE. Operand, sum, carry and counter registers clear to 0. `in_ready`=1 after reset, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0. Reset mid-RUN or mid-DONE aborts the operation silently; no partial result is ever presented.
- `in_ready` = (state==IDLE) || (state==DONE && `out_ready`).
- Accept happens when `in_valid && in_ready`. On accept:
  - latch `a`, `b` into shift registers;
  - carry_reg ← `cin`, cnt ← 0;
  - store `a[WIDTH-1]`, `b[WIDTH-1]`;
  - state → RUN.
- RUN, each cycle:
  - `cla` inputs are a_sh[3:0], b_sh[3:0] and carry_reg.
  - At the edge, the new nibble is shifted into sum_sh from the top (sum_sh ← {s, sum_sh[WIDTH-1:4]}).
  - a_sh and b_sh shift right by 4; carry_reg ← `cla` cout; cnt++.
  - When cnt==NIB-1 at the edge, state → DONE.
- DONE:
  - `out_valid`=1; `sum`=sum_sh, `cout`=carry_reg.
  - `ovf` = (a_msb==b_msb) && (sum[WIDTH-1]!=a_msb).
  - Outputs hold stable while `out_valid && !out_ready`.
  - On `out_ready`: if `in_valid` is also high, accept the new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- `in_valid` is ignored in RUN. `out_ready` is ignored when `out_valid`=0.
- Widths: `cnt` is clog2(NIB) bits, minimum 1. No arithmetic beyond `cla` is allowed; carry propagates only through carry_reg.

## Timing
- Latency: accept at edge k gives `out_valid`=1 from cycle k+NIB (after edge k+NIB). For WIDTH=16 that is 4 cycles; for WIDTH=4 it is 1 cycle.
- Throughput with back-to-back handshake: one result per NIB+1 cycles. The DONE cycle overlaps with the accept of the next operation.
- All outputs are registered or decoded from state only. No combinational path from `a`/`b`/`cin` to any output.
- `in_ready` depends combinationally on `out_ready` in DONE only. There is no path from `in_valid` to `out_valid`.
- Simultaneous reset with handshake: reset wins, and the handshake is lost.

## Structure
- Shared package: FSM state enum (IDLE/RUN/DONE) and the nibble width constant 4.
- Sub-module: exactly one instance of the existing `cla` (ports a, b, s, cin, cout), used unmodified.
- Elaboration check: fail if WIDTH%4 != 0 or WIDTH < 4.

## Test plan
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0; `out_valid` rises exactly 4 cycles after accept.
- a=0x7FFF, b=0x0001, cin=0 → `sum`=0x8000, `cout`=0, `ovf`=1. Then a=0x8000, b=0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
- a=0x1234, b=0x4321, cin=1 → `sum`=0x5556, `cout`=0. Hold `out_ready`=0 for 3 cycles: `sum` stays stable, `in_ready`=0, and the new `in_valid` is not accepted.
- Back-to-back: `in_valid` held high with a new pair, `out_ready`=1 in DONE → second accept happens in the DONE cycle, and the second result appears 4 cycles later. Run 1000 random pairs against a reference model (a+b+cin).
- Drop `rst_n` for 1 cycle mid-RUN (cnt=2) → next cycle shows IDLE, `in_ready`=1, `out_valid`=0, `sum`=0; no stale result appears afterwards.
- WIDTH=4 instance: a=0xF, b=0x1, cin=1 → `sum`=0x1, `cout`=1; latency is 1 cycle.
